// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared mode encodings and reference shift function for barrel_shift_pipe
//
// Purpose: mode constants used by the pipelined barrel shifter, plus a
//          bit-by-bit reference model of every mode (up to 64-bit words).
// Contents: MODE_ROL/MODE_LSL/MODE_LSR/MODE_ASR, barrel_ref().

package barrel_pkg;

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;
  localparam logic [1:0] MODE_ASR = 2'b11;

  // Result bit i is picked from its source bit directly rather than by
  // cascading power-of-two shifts, so it is an independent statement of
  // each mode. Only the low 'width' bits of the result are meaningful.
  function automatic logic [63:0] barrel_ref(input logic [63:0] data,
                                             input logic [5:0]  amt,
                                             input logic [1:0]  mode,
                                             input logic [6:0]  width);
    logic [63:0] r;
    logic [6:0]  src;
    logic [6:0]  msb;
    r   = '0;
    msb = width - 7'd1;
    for (int i = 0; i < 64; i++) begin
      src = 7'd0;
      if (7'(i) < width) begin
        case (mode)
          MODE_ROL: begin
            src = 7'(i) + width - {1'b0, amt};
            if (src >= width) src = src - width;
            r[i[5:0]] = data[src[5:0]];
          end
          MODE_LSL: begin
            if (7'(i) >= {1'b0, amt}) begin
              src = 7'(i) - {1'b0, amt};
              r[i[5:0]] = data[src[5:0]];
            end
          end
          MODE_LSR: begin
            src = 7'(i) + {1'b0, amt};
            if (src < width) r[i[5:0]] = data[src[5:0]];
          end
          default: begin
            src = 7'(i) + {1'b0, amt};
            r[i[5:0]] = (src < width) ? data[src[5:0]] : data[msb[5:0]];
          end
        endcase
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// rtl/barrel_stage.sv - one registered conditional shift-by-STEP stage
//
// Purpose: applies a shift/rotate of STEP positions in the carried mode
//          when amt bit log2(STEP) is set, then registers the word together
//          with its valid, mode and amount so they travel as one.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   load enable (pipeline advance)
//   in_valid/data/amt/mode   word entering this stage
//   out_valid/data/amt/mode  registered word leaving this stage

module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_amt,
  output logic [1:0]       out_mode
);

  localparam int BIT = $clog2(STEP);

  logic [WIDTH-1:0] shifted;

  // ASR fills with the current MSB: earlier stages only ever shift right in
  // ASR mode with sign fill, so the MSB here is still the original sign.
  always_comb begin
    shifted = in_data;
    if (in_amt[BIT]) begin
      case (in_mode)
        MODE_ROL: shifted = {in_data[WIDTH-1-STEP:0], in_data[WIDTH-1:WIDTH-STEP]};
        MODE_LSL: shifted = {in_data[WIDTH-1-STEP:0], {STEP{1'b0}}};
        MODE_LSR: shifted = {{STEP{1'b0}}, in_data[WIDTH-1:STEP]};
        default:  shifted = {{STEP{in_data[WIDTH-1]}}, in_data[WIDTH-1:STEP]};
      endcase
    end
  end

  // Data is loaded even for bubbles; only the valid bit gives it meaning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_amt   <= '0;
      out_mode  <= MODE_ROL;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_amt   <= in_amt;
      out_mode  <= in_mode;
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// rtl/barrel_shift_pipe.sv - pipelined WIDTH-bit barrel shifter with valid/ready handshake
//
// Purpose: shifts or rotates a word by 0..WIDTH-1 in mode ROL/LSL/LSR/ASR,
//          one register stage per shift-amount bit, with global stall.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   in_valid, in_ready        input handshake
//   in_data, in_amt, in_mode  operand, shift amount, operation
//   out_valid, out_ready      output handshake
//   out_data                  result, held while stalled

module barrel_shift_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Index 0 is the input port side, index k+1 the output of stage k.
  logic             valid_pipe [0:SHW];
  logic [WIDTH-1:0] data_pipe  [0:SHW];
  logic [SHW-1:0]   amt_pipe   [0:SHW];
  logic [1:0]       mode_pipe  [0:SHW];
  logic             advance;
  logic             unused_tail;

  // The whole pipeline moves together; it only freezes when the last stage
  // holds a result that the consumer is refusing.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign valid_pipe[0] = in_valid;
  assign data_pipe[0]  = in_data;
  assign amt_pipe[0]   = in_amt;
  assign mode_pipe[0]  = in_mode;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .STEP  (1 << k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance),
      .in_valid  (valid_pipe[k]),
      .in_data   (data_pipe[k]),
      .in_amt    (amt_pipe[k]),
      .in_mode   (mode_pipe[k]),
      .out_valid (valid_pipe[k+1]),
      .out_data  (data_pipe[k+1]),
      .out_amt   (amt_pipe[k+1]),
      .out_mode  (mode_pipe[k+1])
    );
  end

  assign out_valid = valid_pipe[SHW];
  assign out_data  = data_pipe[SHW];

  // Amount and mode are spent once the final stage has shifted.
  assign unused_tail = ^{amt_pipe[SHW], mode_pipe[SHW]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb/tb_barrel_shift_pipe.sv - scoreboard bench for barrel_shift_pipe at WIDTH 8 and 32

module tb_barrel_shift_pipe;
  import barrel_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] m;
    logic [7:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  data8, out_data8, cur_exp8;
  logic [2:0]  amt8;
  logic [1:0]  mode8;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] data32, out_data32, cur_exp32;
  logic [4:0]  amt32;
  logic [1:0]  mode32;

  barrel_shift_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(data8), .in_amt(amt8), .in_mode(mode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8)
  );

  barrel_shift_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(data32), .in_amt(amt32), .in_mode(mode32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_data(out_data32)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0]  exp8_q  [$];
  logic [31:0] exp32_q [$];
  int acc8 = 0, emit8 = 0, flushed8 = 0;
  int acc32 = 0, emit32 = 0;
  logic hs8 = 1'b0, hs32 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: at the negedge, inputs and outputs are stable for the coming
  // edge, so a handshake seen here is the transfer made at that edge.
  always @(negedge clk) begin
    hs8 = rst_n && in_valid8 && in_ready8;
    if (hs8) begin
      exp8_q.push_back(cur_exp8);
      acc8++;
    end
    if (rst_n && out_valid8 && out_ready8) begin
      emit8++;
      if (exp8_q.size() == 0) begin
        total++; bad++;
        $display("FAIL out8_unexpected: got %0h expected no output", out_data8);
      end else begin
        check("out8_data", 64'(out_data8), 64'(exp8_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    hs32 = rst_n && in_valid32 && in_ready32;
    if (hs32) begin
      exp32_q.push_back(cur_exp32);
      acc32++;
    end
    if (rst_n && out_valid32 && out_ready32) begin
      emit32++;
      if (exp32_q.size() == 0) begin
        total++; bad++;
        $display("FAIL out32_unexpected: got %0h expected no output", out_data32);
      end else begin
        check("out32_data", 64'(out_data32), 64'(exp32_q.pop_front()));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  // with in_valid still high so calls can run back-to-back.
  task automatic send8(input vec_t v);
    int n;
    n = 0;
    in_valid8 = 1'b1; data8 = v.d; amt8 = v.a; mode8 = v.m; cur_exp8 = v.e;
    @(negedge clk);
    while (!in_ready8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send8_timeout: waited=%0d limit=%0d", n, 200);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle8(input int n);
    in_valid8 = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic random8(input int words);
    int target, cyc;
    target = acc8 + words;
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (acc8 >= target || cyc > 20000) break;
      out_ready8 = ($urandom_range(0, 3) != 0);
      if (!in_valid8 || hs8) begin
        in_valid8 = ($urandom_range(0, 3) != 0);
        data8 = 8'($urandom);
        amt8  = 3'($urandom_range(0, 7));
        mode8 = 2'($urandom_range(0, 3));
        cur_exp8 = 8'(barrel_ref({56'b0, data8}, {3'b0, amt8}, mode8, 7'd8));
      end
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    check("rand8_accepted", 64'(acc8 >= target), 64'(1));
  endtask

  task automatic random32(input int words);
    int target, cyc;
    target = acc32 + words;
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (acc32 >= target || cyc > 20000) break;
      out_ready32 = ($urandom_range(0, 3) != 0);
      if (!in_valid32 || hs32) begin
        in_valid32 = ($urandom_range(0, 3) != 0);
        data32 = $urandom;
        amt32  = 5'($urandom_range(0, 31));
        mode32 = 2'($urandom_range(0, 3));
        cur_exp32 = 32'(barrel_ref({32'b0, data32}, {1'b0, amt32}, mode32, 7'd32));
      end
    end
    in_valid32 = 1'b0;
    out_ready32 = 1'b1;
    check("rand32_accepted", 64'(acc32 >= target), 64'(1));
  endtask

  vec_t burst [0:10];
  vec_t stall [0:4];
  vec_t flight [0:2];

  initial begin
    int run, maxrun, n, cnt;
    burst = '{
      '{8'h96, 3'd0, MODE_ROL, 8'h96}, '{8'h96, 3'd1, MODE_LSL, 8'h2C},
      '{8'h96, 3'd2, MODE_LSR, 8'h25}, '{8'h96, 3'd3, MODE_ASR, 8'hF2},
      '{8'h96, 3'd4, MODE_ROL, 8'h69}, '{8'h96, 3'd5, MODE_LSL, 8'hC0},
      '{8'h96, 3'd6, MODE_LSR, 8'h02}, '{8'h96, 3'd7, MODE_ASR, 8'hFF},
      '{8'h96, 3'd0, MODE_LSL, 8'h96}, '{8'h96, 3'd0, MODE_LSR, 8'h96},
      '{8'h96, 3'd0, MODE_ASR, 8'h96}
    };
    stall = '{
      '{8'h81, 3'd1, MODE_ROL, 8'h03}, '{8'h81, 3'd4, MODE_LSL, 8'h10},
      '{8'h81, 3'd7, MODE_LSR, 8'h01}, '{8'h81, 3'd1, MODE_ASR, 8'hC0},
      '{8'h81, 3'd7, MODE_ROL, 8'hC0}
    };
    flight = '{
      '{8'h0F, 3'd1, MODE_LSL, 8'h1E}, '{8'hF0, 3'd2, MODE_LSR, 8'h3C},
      '{8'h55, 3'd1, MODE_ROL, 8'hAA}
    };

    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; data8 = '0; amt8 = '0; mode8 = '0; cur_exp8 = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; data32 = '0; amt32 = '0; mode32 = '0; cur_exp32 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid8", 64'(out_valid8), 64'(0));
    check("rst_out_data8", 64'(out_data8), 64'(0));
    check("rst_in_ready8", 64'(in_ready8), 64'(1));
    check("rst_out_valid32", 64'(out_valid32), 64'(0));
    check("rst_out_data32", 64'(out_data32), 64'(0));
    rst_n = 1'b1;
    idle8(2);

    // Latency: the accepting edge plus two more edges reach the last stage.
    send8('{8'b01001100, 3'd3, MODE_ROL, 8'b01100010});
    in_valid8 = 1'b0;
    check("lat_edge1_valid", 64'(out_valid8), 64'(0));
    @(posedge clk); #1;
    check("lat_edge2_valid", 64'(out_valid8), 64'(0));
    @(posedge clk); #1;
    check("lat_edge3_valid", 64'(out_valid8), 64'(1));
    check("lat_edge3_data", 64'(out_data8), 64'(8'b01100010));
    idle8(4);

    send8('{8'b01001100, 3'd2, MODE_LSL, 8'b00110000});
    send8('{8'b01001100, 3'd5, MODE_LSR, 8'b00000010});
    send8('{8'b10110000, 3'd3, MODE_ASR, 8'b11110110});
    idle8(6);

    // Back-to-back burst must leave as one unbroken run of valid cycles.
    run = 0; maxrun = 0;
    fork
      begin
        for (int i = 0; i < 11; i++) send8(burst[i]);
        in_valid8 = 1'b0;
      end
      begin
        #1;
        repeat (25) begin
          if (out_valid8) begin
            run++;
            if (run > maxrun) maxrun = run;
          end else begin
            run = 0;
          end
          @(posedge clk); #2;
        end
      end
    join
    check("burst_run_length", 64'(maxrun), 64'(11));
    idle8(4);

    // Backpressure with the pipeline full.
    out_ready8 = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send8(stall[i]);
        in_valid8 = 1'b0;
      end
      begin
        n = 0;
        #1;
        while (!out_valid8 && n < 50) begin
          @(posedge clk); #2;
          n++;
        end
        repeat (4) begin
          check("stall_in_ready", 64'(in_ready8), 64'(0));
          check("stall_out_valid", 64'(out_valid8), 64'(1));
          check("stall_out_data", 64'(out_data8), 64'(8'h03));
          @(posedge clk); #2;
        end
        out_ready8 = 1'b1;
      end
    join
    idle8(8);

    // Reset with three words in flight.
    for (int i = 0; i < 3; i++) send8(flight[i]);
    in_valid8 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("flight_rst_out_valid", 64'(out_valid8), 64'(0));
    check("flight_rst_out_data", 64'(out_data8), 64'(0));
    check("flight_rst_in_ready", 64'(in_ready8), 64'(1));
    flushed8 += exp8_q.size();
    exp8_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      if (out_valid8) cnt++;
      @(posedge clk); #1;
    end
    check("flight_no_emit", 64'(cnt), 64'(0));
    check("flight_in_ready", 64'(in_ready8), 64'(1));

    fork
      random8(1000);
      random32(1000);
    join

    n = 0;
    while ((exp8_q.size() != 0 || exp32_q.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain8_empty", 64'(exp8_q.size()), 64'(0));
    check("drain32_empty", 64'(exp32_q.size()), 64'(0));
    check("count8_exact", 64'(emit8), 64'(acc8 - flushed8));
    check("count32_exact", 64'(emit32), 64'(acc32));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time=%0t limit=%0t", $time, 1000000);
    $fatal(1);
  end

endmodule
